// File: rtl/env_step_pkg.sv
// Shared grid-world types and constants for the environment
// stage and the agent's exploration logic.
package q_env_pkg;

    localparam int ROW_BITS   = 3;
    localparam int COL_BITS   = 3;
    localparam int ACT_BITS   = 2;
    localparam int STATE_W    = ROW_BITS + COL_BITS;
    localparam int ADDR_W     = STATE_W + ACT_BITS;
    localparam int DATA_WIDTH = 32;
    localparam int STEP_W     = 16;
    localparam int EP_W       = 16;
    localparam int NUM_ROWS   = 1 << ROW_BITS;
    localparam int NUM_COLS   = 1 << COL_BITS;

    typedef logic [STATE_W-1:0]  grid_t;
    typedef logic [ACT_BITS-1:0] act_t;

    localparam grid_t GOAL_STATE  = 6'b111_111;
    localparam grid_t START_STATE = '0;

    localparam act_t ACT_LEFT  = 2'b00;
    localparam act_t ACT_UP    = 2'b01;
    localparam act_t ACT_RIGHT = 2'b10;
    localparam act_t ACT_DOWN  = 2'b11;

    localparam logic [ROW_BITS-1:0] ROW_MAX =
        ROW_BITS'(NUM_ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX =
        COL_BITS'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAP,
        OUT
    } fsm_t;

endpackage

// File: rtl/env_step_if.sv
// Agent request, reward-ROM and result buses of env_step.
// o_timeout exists only when ENV_STEP_LIMIT_EN is defined.
interface env_step_if;
    import q_env_pkg::*;

    logic                  i_valid;
    logic                  o_ready;
    grid_t                 i_state;
    act_t                  i_action;
    logic [ADDR_W-1:0]     o_raddr;
    logic                  o_rread;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_reward;
    grid_t                 o_next_state;
    logic                  o_done;
    logic [STEP_W-1:0]     o_step_cnt;
    logic [EP_W-1:0]       o_ep_cnt;
`ifdef ENV_STEP_LIMIT_EN
    logic                  o_timeout;
`endif

    modport slave (
        input  i_valid, i_state, i_action,
        input  i_rdata, i_ready,
        output o_ready, o_raddr, o_rread,
        output o_valid, o_reward, o_next_state,
`ifdef ENV_STEP_LIMIT_EN
        output o_timeout,
`endif
        output o_done, o_step_cnt, o_ep_cnt
    );

    modport master (
        output i_valid, i_state, i_action,
        output i_rdata, i_ready,
        input  o_ready, o_raddr, o_rread,
        input  o_valid, o_reward, o_next_state,
`ifdef ENV_STEP_LIMIT_EN
        input  o_timeout,
`endif
        input  o_done, o_step_cnt, o_ep_cnt
    );

endinterface

// File: rtl/env_step_grid_move.sv
// Combinational grid move with wall clamping; no wrap-around.
module grid_move
    import q_env_pkg::*;
(
    input  grid_t state,
    input  act_t  action,
    output grid_t next_state,
    output logic  wall_hit
);

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;

    assign row = state[STATE_W-1:COL_BITS];
    assign col = state[COL_BITS-1:0];

    always_comb begin
        next_state = state;
        wall_hit   = 1'b0;
        unique case (action)
            ACT_LEFT:
                if (col == '0) wall_hit = 1'b1;
                else next_state = {row, col - 1'b1};
            ACT_UP:
                if (row == '0) wall_hit = 1'b1;
                else next_state = {row - 1'b1, col};
            ACT_RIGHT:
                if (col == COL_MAX) wall_hit = 1'b1;
                else next_state = {row, col + 1'b1};
            ACT_DOWN:
                if (row == ROW_MAX) wall_hit = 1'b1;
                else next_state = {row + 1'b1, col};
        endcase
    end

endmodule

// File: rtl/env_step.sv
// Grid-world environment step: ROM lookup, move, goal detect.
// ENV_STEP_LIMIT_EN adds the MAX_STEPS episode limit and o_timeout.
module env_step
    import q_env_pkg::*;
`ifdef ENV_STEP_LIMIT_EN
#(
    parameter int MAX_STEPS = 256
)
`endif
(
    input logic       i_clk,
    input logic       i_rst,
    env_step_if.slave bus
);

    fsm_t                  state, state_d;
    logic                  accept, capture, retire;
    logic [ADDR_W-1:0]     raddr;
    logic                  rread;
    logic                  valid;
    logic [DATA_WIDTH-1:0] reward;
    grid_t                 next_state;
    grid_t                 move_ns;
    logic                  done;
    logic                  goal;
    logic                  end_ep;
    logic                  unused_wall;
    logic [STEP_W-1:0]     step_cnt;
    logic [EP_W-1:0]       ep_cnt;

    // raddr doubles as the latched {state, action} of the step
    grid_move u_move (
        .state      (raddr[ADDR_W-1:ACT_BITS]),
        .action     (raddr[ACT_BITS-1:0]),
        .next_state (move_ns),
        .wall_hit   (unused_wall)
    );

    assign goal = (move_ns == GOAL_STATE);

`ifdef ENV_STEP_LIMIT_EN
    logic limit;
    logic timeout;

    assign limit  = (step_cnt == STEP_W'(MAX_STEPS - 1));
    assign end_ep = goal | limit;
`else
    assign end_ep = goal;
`endif

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        unique case (state)
            IDLE:
                if (bus.i_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            ISSUE:
                state_d = CAP;
            CAP: begin
                capture = 1'b1;
                state_d = OUT;
            end
            OUT:
                if (bus.i_ready) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            raddr      <= '0;
            rread      <= 1'b0;
            valid      <= 1'b0;
            reward     <= '0;
            next_state <= '0;
            done       <= 1'b0;
            step_cnt   <= '0;
            ep_cnt     <= '0;
`ifdef ENV_STEP_LIMIT_EN
            timeout    <= 1'b0;
`endif
        end else begin
            rread <= accept;
            if (accept) begin
                raddr <= {bus.i_state, bus.i_action};
            end
            if (capture) begin
                reward     <= bus.i_rdata;
                next_state <= move_ns;
                done       <= end_ep;
                valid      <= 1'b1;
`ifdef ENV_STEP_LIMIT_EN
                timeout    <= limit & ~goal;
`endif
            end
            if (retire) begin
                valid <= 1'b0;
                if (done) begin
                    step_cnt <= '0;
                    ep_cnt   <= ep_cnt + 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_ready      = (state == IDLE);
    assign bus.o_raddr      = raddr;
    assign bus.o_rread      = rread;
    assign bus.o_valid      = valid;
    assign bus.o_reward     = reward;
    assign bus.o_next_state = next_state;
    assign bus.o_done       = done;
    assign bus.o_step_cnt   = step_cnt;
    assign bus.o_ep_cnt     = ep_cnt;
`ifdef ENV_STEP_LIMIT_EN
    assign bus.o_timeout    = timeout;
`endif

endmodule

// File: tb/tb_env_step.sv
// Directed bench for env_step with a registered reward-ROM model.
// Define ENV_STEP_LIMIT_EN to also run the MAX_STEPS = 4 scenario.
module tb_env_step;
    import q_env_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    env_step_if bus ();

`ifdef ENV_STEP_LIMIT_EN
    env_step #(.MAX_STEPS(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
`else
    env_step dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
`endif

    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'h01:   return 32'hFF000001;
            8'h73:   return 32'h00000000;
            8'hDF:   return 32'h00FFFFFF;
            default: return {24'hA5A5A5, a};
        endcase
    endfunction

    // ROM samples the address each edge; data valid the next cycle
    always @(posedge clk) bus.i_rdata <= rom(bus.o_raddr);

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge in OUT
    task automatic issue(input grid_t st, input act_t act,
                         input logic [7:0] eaddr,
                         input logic [31:0] erew,
                         input grid_t ens, input logic edone);
        chk("ready_pre", bus.o_ready, 1);
        bus.i_valid  = 1'b1;
        bus.i_state  = st;
        bus.i_action = act;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_state  = ~st;
        bus.i_action = ~act;
        chk("rread_pulse", bus.o_rread, 1);
        chk("raddr", bus.o_raddr, eaddr);
        chk("ready_busy", bus.o_ready, 0);
        chk("valid_lat0", bus.o_valid, 0);
        @(negedge clk);
        chk("rread_low", bus.o_rread, 0);
        chk("valid_lat1", bus.o_valid, 0);
        chk("raddr_hold", bus.o_raddr, eaddr);
        @(negedge clk);
        chk("valid_lat2", bus.o_valid, 1);
        chk("reward", bus.o_reward, erew);
        chk("next_state", bus.o_next_state, ens);
        chk("done", bus.o_done, edone);
    endtask

    task automatic retire(input logic [15:0] estep,
                          input logic [15:0] eep);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        chk("valid_drop", bus.o_valid, 0);
        chk("ready_back", bus.o_ready, 1);
        chk("step_cnt", bus.o_step_cnt, estep);
        chk("ep_cnt", bus.o_ep_cnt, eep);
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_state  = '0;
        bus.i_action = '0;
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_rread", bus.o_rread, 0);
        chk("rst_raddr", bus.o_raddr, 0);
        chk("rst_reward", bus.o_reward, 0);
        chk("rst_ns", bus.o_next_state, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_step", bus.o_step_cnt, 0);
        chk("rst_ep", bus.o_ep_cnt, 0);
        chk("rst_ready", bus.o_ready, 1);
`ifdef ENV_STEP_LIMIT_EN
        chk("rst_timeout", bus.o_timeout, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // interior move, wall bump, right wall, goal
        issue(6'o34, ACT_DOWN, 8'h73, 32'h0, 6'o44, 0);
        retire(1, 0);
        issue(6'o00, ACT_UP, 8'h01, 32'hFF000001, 6'o00, 0);
        retire(2, 0);
        issue(6'o57, ACT_RIGHT, 8'hBE, 32'hA5A5A5BE, 6'o57, 0);
        retire(3, 0);
        issue(6'o67, ACT_DOWN, 8'hDF, 32'h00FFFFFF, 6'o77, 1);
`ifdef ENV_STEP_LIMIT_EN
        chk("goal_no_timeout", bus.o_timeout, 0);
`endif
        retire(0, 1);

        // backpressure with spurious requests
        issue(6'o00, ACT_RIGHT, 8'h02, 32'hA5A5A502, 6'o01, 0);
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1;
            bus.i_state = 6'(i + 9);
            @(negedge clk);
            chk("bp_valid", bus.o_valid, 1);
            chk("bp_ready", bus.o_ready, 0);
            chk("bp_rread", bus.o_rread, 0);
            chk("bp_raddr", bus.o_raddr, 8'h02);
            chk("bp_reward", bus.o_reward, 32'hA5A5A502);
            chk("bp_ns", bus.o_next_state, 6'o01);
            chk("bp_step", bus.o_step_cnt, 0);
        end
        bus.i_valid = 1'b0;
        retire(1, 1);
        @(negedge clk);
        chk("bp_once_valid", bus.o_valid, 0);
        chk("bp_once_rread", bus.o_rread, 0);
        chk("bp_once_step", bus.o_step_cnt, 1);

        // reset while in CAP
        bus.i_valid  = 1'b1;
        bus.i_state  = 6'o70;
        bus.i_action = ACT_DOWN;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_valid", bus.o_valid, 0);
        chk("mid_rread", bus.o_rread, 0);
        chk("mid_raddr", bus.o_raddr, 0);
        chk("mid_ready", bus.o_ready, 1);
        chk("mid_step", bus.o_step_cnt, 0);
        chk("mid_ep", bus.o_ep_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_no_out", bus.o_valid, 0);
        issue(6'o70, ACT_UP, 8'hE1, 32'hA5A5A5E1, 6'o60, 0);
        retire(1, 0);
        issue(6'o70, ACT_DOWN, 8'hE3, 32'hA5A5A5E3, 6'o70, 0);
        retire(2, 0);
        issue(6'o30, ACT_LEFT, 8'h60, 32'hA5A5A560, 6'o30, 0);
        retire(3, 0);

`ifdef ENV_STEP_LIMIT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(6'o33, ACT_RIGHT, 8'h6E, 32'hA5A5A56E, 6'o34, 0);
        retire(1, 0);
        issue(6'o34, ACT_DOWN, 8'h73, 32'h0, 6'o44, 0);
        retire(2, 0);
        issue(6'o44, ACT_LEFT, 8'h90, 32'hA5A5A590, 6'o43, 0);
        chk("lim_timeout_lo", bus.o_timeout, 0);
        retire(3, 0);
        issue(6'o43, ACT_UP, 8'h8D, 32'hA5A5A58D, 6'o33, 1);
        chk("lim_timeout_hi", bus.o_timeout, 1);
        retire(0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
